operand_fetch_stage: RTL and testbench
======================================

# operand_fetch_stage

Register-file and operand-sequencing stage directly upstream of the 16-bit ALU in the RISC datapath. It accepts one instruction's register fields, reads the two source operands over successive cycles, and applies the optional shift to the B operand. It then presents Ain/Bin/ALUop to the ALU for one execute cycle, captures the ALU result and its 3-bit status (V,N,Z), and writes the result back to the destination register.

## Interface
Parameters:
- REGS, 8, number of 16-bit general registers (address width 3)
- WIDTH, 16, datapath width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin an instruction; accepted only in IDLE
- rn  in  3  source register for Ain
- rm  in  3  source register for Bin (pre-shift)
- rd  in  3  destination register
- shift  in  2  B shift: 00 none, 01 shl1 (LSB←0), 10 lsr1 (MSB←0), 11 asr1 (MSB←B[15])
- op_in  in  2  ALU operation code, forwarded as ALUop
- a_zero  in  1  force Ain to 0 (MOV form)
- write_en  in  1  write result to rd in WB
- status_en  in  1  update status from ALU Z in EXEC
- ext_we  in  1  external register load (init/debug), honoured only in IDLE
- ext_addr  in  3  external load address
- ext_data  in  16  external load data
- alu_out  in  16  ALU result
- alu_z  in  3  ALU flags {V,N,Z}
- Ain  out  16  operand A to ALU
- Bin  out  16  shifted operand B to ALU
- ALUop  out  2  latched op_in
- alu_valid  out  1  high only in EXEC
- status  out  3  latched {V,N,Z}
- result  out  16  latched ALU result (C register)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse in WB

## Operation
- FSM states: IDLE → LOAD_A → LOAD_B → EXEC → WB → IDLE; there are no other transitions.
- IDLE: on start, latch rn, rm, rd, shift, op_in, a_zero, write_en, status_en; go to LOAD_A. start is ignored outside IDLE; no queuing.
- LOAD_A: A ← R[rn]. LOAD_B: B ← R[rm].
- EXEC:
  - alu_valid=1. Ain = a_zero ? 0 : A. Bin = shift(B). ALUop = latched op.
  - On the EXEC clock edge, C ← alu_out; if status_en, status ← alu_z, otherwise status is held.
- WB: if write_en, R[rd] ← C. done=1.
- Outside EXEC, Ain/Bin/ALUop still reflect the latches; the ALU ignores them because alu_valid=0.
- rd == rn or rd == rm is legal: the write occurs in WB, after both reads.
- ext_we in IDLE writes R[ext_addr] ← ext_data. ext_we is ignored in any other state.
- ext_we and start in the same IDLE cycle: both are honoured. The write lands on that edge, so LOAD_A/LOAD_B see the new value.
- Shift arithmetic is mod 2^16, and bits shifted out are lost.

## Timing
- start sampled at edge 0 → LOAD_A in cycle 1, LOAD_B in cycle 2, EXEC in cycle 3, WB/done in cycle 4, IDLE in cycle 5. The next start is accepted from cycle 5, giving 5 cycles per instruction.
- Register writes become visible to reads on the following cycle. There is no write-through bypass.
- Reset, at any point including mid-instruction:
  - State goes to IDLE.
  - A, B, C, all registers R0–R7, latched fields, and status go to 0.
  - busy, done and alu_valid go to 0.
  - A WB coinciding with reset does not write.

## Structure
- Shared package `datapath_pkg`:
  - state enum (IDLE, LOAD_A, LOAD_B, EXEC, WB)
  - shift codes (SH_NONE, SH_SHL, SH_LSR, SH_ASR)
  - flag bit indices (FLAG_Z=0, FLAG_N=1, FLAG_V=2), shared with the ALU
- One combinational sub-module, `shifter16`, implements the four shift codes.
- Register file, latches and FSM stay in this module.

## Test plan
- ext-load R0=7, R1=2. Start rn=0, rm=1, rd=2, op 00, shift 00, write_en=1 → Ain=7, Bin=2 with alu_valid in cycle 3; done in cycle 4; R2=9 afterwards.
- ext-load R3=16'h8001. Start a_zero=1, rm=3, shift 11, rd=4 → Bin=16'hC000, Ain=0; R4=16'hC000. Repeat with shift 01 → Bin=16'h0002, and with shift 10 → Bin=16'h4000.
- ext-load R0=R1=5. Start op 01, status_en=1, write_en=0 → status=3'b001, registers unchanged. Next instruction with status_en=0 → status holds 3'b001.
- Assert start during cycles 1–4 of an instruction → it is ignored; busy stays high; exactly one done pulse is produced.
- Assert reset in cycle 3 (EXEC) → the next cycle is IDLE, R[rd] is not written, status=0, result=0, done never pulses.
- Same-cycle ext_we (R5←16'h1234) and start with rn=5 → Ain=16'h1234 in EXEC.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared datapath definitions: FSM states, shift codes and ALU flag bit positions.
package datapath_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    EXEC,
    WB
  } state_t;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_SHL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_t;

  // Bit positions inside the {V,N,Z} status vector, shared with the ALU.
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 2;

endpackage

// File: rtl/shifter16.sv
// Single-bit B-operand shifter: pass, shift left, logical right or arithmetic right.
module shifter16
  import datapath_pkg::*;
(
  input  logic [15:0] din,
  input  logic [1:0]  sh,
  output logic [15:0] dout
);

  always_comb begin
    dout = din;
    case (shift_t'(sh))
      SH_NONE: dout = din;
      SH_SHL:  dout = {din[14:0], 1'b0};
      SH_LSR:  dout = {1'b0, din[15:1]};
      SH_ASR:  dout = {din[15], din[15:1]};
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Register file plus operand sequencer feeding the ALU: fetch A, fetch B,
// execute for one cycle, then write the captured result back.
module operand_fetch_stage
  import datapath_pkg::*;
#(
  parameter int REGS  = 8,
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [$clog2(REGS)-1:0] rn,
  input  logic [$clog2(REGS)-1:0] rm,
  input  logic [$clog2(REGS)-1:0] rd,
  input  logic [1:0]              shift,
  input  logic [1:0]              op_in,
  input  logic                    a_zero,
  input  logic                    write_en,
  input  logic                    status_en,
  input  logic                    ext_we,
  input  logic [$clog2(REGS)-1:0] ext_addr,
  input  logic [WIDTH-1:0]        ext_data,
  input  logic [WIDTH-1:0]        alu_out,
  input  logic [2:0]              alu_z,
  output logic [WIDTH-1:0]        Ain,
  output logic [WIDTH-1:0]        Bin,
  output logic [1:0]              ALUop,
  output logic                    alu_valid,
  output logic [2:0]              status,
  output logic [WIDTH-1:0]        result,
  output logic                    busy,
  output logic                    done
);

  localparam int AW = $clog2(REGS);

  state_t state, nextState;

  logic [WIDTH-1:0] regs [REGS];
  logic [WIDTH-1:0] aReg, bReg, cReg;
  logic [AW-1:0]    rnLat, rmLat, rdLat;
  logic [1:0]       shiftLat, opLat;
  logic             aZeroLat, writeEnLat, statusEnLat;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = LOAD_A;
      LOAD_A:  nextState = LOAD_B;
      LOAD_B:  nextState = EXEC;
      EXEC:    nextState = WB;
      WB:      nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    alu_valid = (state == EXEC);
    done      = (state == WB);
    busy      = (state != IDLE);
  end

  // Instruction fields are captured only when a new instruction is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      rnLat       <= '0;
      rmLat       <= '0;
      rdLat       <= '0;
      shiftLat    <= '0;
      opLat       <= '0;
      aZeroLat    <= 1'b0;
      writeEnLat  <= 1'b0;
      statusEnLat <= 1'b0;
    end else if (state == IDLE && start) begin
      rnLat       <= rn;
      rmLat       <= rm;
      rdLat       <= rd;
      shiftLat    <= shift;
      opLat       <= op_in;
      aZeroLat    <= a_zero;
      writeEnLat  <= write_en;
      statusEnLat <= status_en;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      aReg   <= '0;
      bReg   <= '0;
      cReg   <= '0;
      status <= '0;
    end else begin
      if (state == LOAD_A) aReg <= regs[rnLat];
      if (state == LOAD_B) bReg <= regs[rmLat];
      if (state == EXEC) begin
        cReg <= alu_out;
        if (statusEnLat) status <= alu_z;
      end
    end
  end

  // External loads and writeback can never collide: one is IDLE-only, the other WB-only.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REGS; i++) regs[i] <= '0;
    end else if (state == IDLE && ext_we) begin
      regs[ext_addr] <= ext_data;
    end else if (state == WB && writeEnLat) begin
      regs[rdLat] <= cReg;
    end
  end

  shifter16 uShifter (
    .din  (bReg),
    .sh   (shiftLat),
    .dout (Bin)
  );

  assign Ain    = aZeroLat ? '0 : aReg;
  assign ALUop  = opLat;
  assign result = cReg;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage with a small behavioural ALU closing the loop.
module tb_operand_fetch_stage;
  import datapath_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, a_zero, write_en, status_en, ext_we;
  logic [2:0]  rn, rm, rd, ext_addr;
  logic [1:0]  shift, op_in;
  logic [15:0] ext_data, alu_out;
  logic [2:0]  alu_z;
  logic [15:0] Ain, Bin, result;
  logic [1:0]  ALUop;
  logic        alu_valid, busy, done;
  logic [2:0]  status;

  int compared   = 0;
  int mismatched = 0;
  int doneCount;

  always #5 clk = ~clk;

  operand_fetch_stage #(.REGS(8), .WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .rn(rn), .rm(rm), .rd(rd),
    .shift(shift), .op_in(op_in), .a_zero(a_zero), .write_en(write_en),
    .status_en(status_en), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_data(ext_data), .alu_out(alu_out), .alu_z(alu_z), .Ain(Ain),
    .Bin(Bin), .ALUop(ALUop), .alu_valid(alu_valid), .status(status),
    .result(result), .busy(busy), .done(done)
  );

  // Reference ALU: 00 add, 01 sub, 10 and, 11 not B.
  always_comb begin
    alu_out = '0;
    alu_z   = '0;
    case (ALUop)
      2'b00: alu_out = Ain + Bin;
      2'b01: alu_out = Ain - Bin;
      2'b10: alu_out = Ain & Bin;
      default: alu_out = ~Bin;
    endcase
    alu_z[FLAG_Z] = (alu_out == 16'h0000);
    alu_z[FLAG_N] = alu_out[15];
    if (ALUop == 2'b00)      alu_z[FLAG_V] = (Ain[15] == Bin[15]) && (alu_out[15] != Ain[15]);
    else if (ALUop == 2'b01) alu_z[FLAG_V] = (Ain[15] != Bin[15]) && (alu_out[15] != Ain[15]);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic extLoad(input logic [2:0] addr, input logic [15:0] data);
    ext_we = 1'b1; ext_addr = addr; ext_data = data;
    @(negedge clk);
    ext_we = 1'b0;
  endtask

  // Presents one instruction for a single edge; returns in cycle 1 (LOAD_A).
  task automatic applyStimulus(input logic [2:0] irn, input logic [2:0] irm, input logic [2:0] ird,
                               input logic [1:0] ish, input logic [1:0] iop, input logic iaz,
                               input logic iwe, input logic ise);
    rn = irn; rm = irm; rd = ird; shift = ish; op_in = iop;
    a_zero = iaz; write_en = iwe; status_en = ise; start = 1'b1;
    @(negedge clk);
    start = 1'b0; ext_we = 1'b0;
  endtask

  // Walks cycles 1..5 of an instruction already started.
  task automatic runInstr(input string tag, input logic [15:0] expA, input logic [15:0] expB,
                          input logic [15:0] expC);
    checkOutput({tag, ".busy1"}, 32'(busy), 32'd1);
    @(negedge clk);
    @(negedge clk);
    checkOutput({tag, ".valid3"}, 32'(alu_valid), 32'd1);
    checkOutput({tag, ".Ain"}, 32'(Ain), 32'(expA));
    checkOutput({tag, ".Bin"}, 32'(Bin), 32'(expB));
    @(negedge clk);
    checkOutput({tag, ".done4"}, 32'(done), 32'd1);
    checkOutput({tag, ".result"}, 32'(result), 32'(expC));
    @(negedge clk);
    checkOutput({tag, ".idle5"}, 32'(busy), 32'd0);
  endtask

  // Reads a register through the B path (MOV form, no write, no status update).
  task automatic readReg(input string tag, input logic [2:0] addr, input logic [15:0] expVal);
    applyStimulus(3'd0, addr, 3'd0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkOutput(tag, 32'(Bin), 32'(expVal));
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; rn = '0; rm = '0; rd = '0; shift = '0; op_in = '0;
    a_zero = 1'b0; write_en = 1'b0; status_en = 1'b0;
    ext_we = 1'b0; ext_addr = '0; ext_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst.busy", 32'(busy), 32'd0);
    checkOutput("rst.done", 32'(done), 32'd0);
    checkOutput("rst.valid", 32'(alu_valid), 32'd0);
    checkOutput("rst.status", 32'(status), 32'd0);
    checkOutput("rst.result", 32'(result), 32'd0);
    checkOutput("rst.Ain", 32'(Ain), 32'd0);
    checkOutput("rst.Bin", 32'(Bin), 32'd0);

    extLoad(3'd0, 16'd7);
    extLoad(3'd1, 16'd2);
    applyStimulus(3'd0, 3'd1, 3'd2, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    runInstr("add", 16'd7, 16'd2, 16'd9);
    readReg("add.R2", 3'd2, 16'd9);

    extLoad(3'd3, 16'h8001);
    applyStimulus(3'd0, 3'd3, 3'd4, 2'b11, 2'b00, 1'b1, 1'b1, 1'b0);
    runInstr("asr", 16'h0000, 16'hC000, 16'hC000);
    readReg("asr.R4", 3'd4, 16'hC000);
    applyStimulus(3'd0, 3'd3, 3'd4, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0);
    runInstr("shl", 16'h0000, 16'h0002, 16'h0002);
    applyStimulus(3'd0, 3'd3, 3'd4, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0);
    runInstr("lsr", 16'h0000, 16'h4000, 16'h4000);
    readReg("nowb.R4", 3'd4, 16'hC000);

    extLoad(3'd0, 16'd5);
    extLoad(3'd1, 16'd5);
    applyStimulus(3'd0, 3'd1, 3'd2, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1);
    runInstr("sub", 16'd5, 16'd5, 16'd0);
    checkOutput("sub.status", 32'(status), 32'b001);
    readReg("sub.R2", 3'd2, 16'd9);
    checkOutput("hold.status", 32'(status), 32'b001);

    // start held high through cycles 1-4 must not queue a second instruction.
    applyStimulus(3'd0, 3'd1, 3'd5, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    doneCount = 0;
    for (int c = 1; c <= 7; c++) begin
      start = (c <= 4);
      if (done) doneCount++;
      if (c <= 4) checkOutput($sformatf("ign.busy%0d", c), 32'(busy), 32'd1);
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput("ign.doneCount", 32'(doneCount), 32'd1);
    checkOutput("ign.idle", 32'(busy), 32'd0);

    // Reset during EXEC aborts the instruction before writeback.
    applyStimulus(3'd0, 3'd1, 3'd7, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("mid.busy", 32'(busy), 32'd0);
    checkOutput("mid.valid", 32'(alu_valid), 32'd0);
    checkOutput("mid.status", 32'(status), 32'd0);
    checkOutput("mid.result", 32'(result), 32'd0);
    doneCount = 0;
    for (int c = 0; c < 4; c++) begin
      if (done) doneCount++;
      @(negedge clk);
    end
    checkOutput("mid.noDone", 32'(doneCount), 32'd0);
    readReg("mid.R7", 3'd7, 16'd0);
    readReg("mid.R0", 3'd0, 16'd0);

    // External write and start on the same edge: LOAD_A sees the new value.
    ext_we = 1'b1; ext_addr = 3'd5; ext_data = 16'h1234;
    applyStimulus(3'd5, 3'd5, 3'd6, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    runInstr("same", 16'h1234, 16'h1234, 16'h2468);
    readReg("same.R6", 3'd6, 16'h2468);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
